// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mac_pkg
// Description : Shared sizing helpers and lane unpack for packed MAC datapaths
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

  localparam int c_data_w     = 8;
  localparam int c_max_lane_w = 64;

  function automatic int lane_w(input int data_w, input int acc_len);
    return 2 * data_w + $clog2(acc_len) + 1;
  endfunction

  function automatic int pack_w(input int data_w, input int lane_width);
    return 2 * lane_width + data_w;
  endfunction

  // A negative lower lane borrowed one from the lane above it; add it back.
  function automatic logic [c_max_lane_w-1:0] unpack_hi(
    input logic [c_max_lane_w-1:0] hi_field,
    input logic                    lo_sign
  );
    return hi_field + {{(c_max_lane_w-1){1'b0}}, lo_sign};
  endfunction

endpackage
`default_nettype wire

// File: rtl/packed_mult_stage.sv
`default_nettype none
// ============================================================================
// Module      : packed_mult_stage
// Description : Operand register + packed multiply register (one DSP slice)
// Revision    : 1.0 - initial release
// ============================================================================
module packed_mult_stage
  import mac_pkg::*;
#(
  parameter int DATA_W = c_data_w,
  parameter int LANE_W = lane_w(c_data_w, 9),
  parameter int PACK_W = pack_w(c_data_w, lane_w(c_data_w, 9)),
  parameter int TAG_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic signed [DATA_W-1:0] in_a_lo,
  input  logic signed [DATA_W-1:0] in_a_hi,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     p_valid,
  output logic [TAG_W-1:0]         p_tag,
  output logic [PACK_W-1:0]        p
);

  logic                     r_v1;
  logic [TAG_W-1:0]         r_tag1;
  logic signed [DATA_W-1:0] r_a_lo;
  logic signed [DATA_W-1:0] r_a_hi;
  logic signed [DATA_W-1:0] r_b;
  logic                     r_v2;
  logic [TAG_W-1:0]         r_tag2;
  logic [PACK_W-1:0]        r_p;
  logic signed [PACK_W-1:0] w_a_pack;
  logic signed [PACK_W-1:0] w_b_ext;
  logic signed [PACK_W-1:0] w_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_tag1 <= '0;
      r_a_lo <= '0;
      r_a_hi <= '0;
      r_b    <= '0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_tag1 <= in_tag;
        r_a_lo <= in_a_lo;
        r_a_hi <= in_a_hi;
        r_b    <= in_b;
      end
    end
  end

  // Modular PACK_W product: both lanes stay exact because each fits its lane.
  always_comb begin
    w_a_pack = PACK_W'(r_a_lo) + (PACK_W'(r_a_hi) << LANE_W);
    w_b_ext  = PACK_W'(r_b);
    w_prod   = w_a_pack * w_b_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_tag2 <= '0;
      r_p    <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_tag2 <= r_tag1;
        r_p    <= w_prod;
      end
    end
  end

  assign p_valid = r_v2;
  assign p_tag   = r_tag2;
  assign p       = r_p;

endmodule
`default_nettype wire

// File: rtl/packed_dual_mac.sv
`default_nettype none
// ============================================================================
// Module      : packed_dual_mac
// Description : Two-filter packed MAC over ACC_LEN-beat windows with unpack
// Revision    : 1.0 - initial release
// ============================================================================
module packed_dual_mac
  import mac_pkg::*;
#(
  parameter int DATA_W  = c_data_w,
  parameter int ACC_LEN = 9,
  parameter int LANE_W  = lane_w(DATA_W, ACC_LEN),
  parameter int PACK_W  = pack_w(DATA_W, LANE_W)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic signed [DATA_W-1:0]       in_a_lo,
  input  logic signed [DATA_W-1:0]       in_a_hi,
  input  logic signed [DATA_W-1:0]       in_b,
  output logic                           out_valid,
  output logic signed [LANE_W-1:0]       out_lo,
  output logic signed [LANE_W-1:0]       out_hi,
  output logic [$clog2(ACC_LEN+1)-1:0]   beat_cnt
);

  localparam int               c_cnt_w    = $clog2(ACC_LEN + 1);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(ACC_LEN - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               w_first;
  logic               w_last;
  logic               w_p_valid;
  logic [1:0]         w_p_tag;
  logic [PACK_W-1:0]  w_p;
  logic [PACK_W-1:0]  r_acc;
  logic               r_last3;
  logic [LANE_W-1:0]  w_lo;
  logic [LANE_W-1:0]  w_hi;
  logic               w_unused_acc_top;
  logic               r_out_valid;
  logic [LANE_W-1:0]  r_out_lo;
  logic [LANE_W-1:0]  r_out_hi;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == c_last_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (in_valid) begin
      r_cnt <= w_last ? '0 : r_cnt + c_cnt_w'(1);
    end
  end

  packed_mult_stage #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .PACK_W (PACK_W),
    .TAG_W  (2)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_tag   ({w_first, w_last}),
    .in_a_lo  (in_a_lo),
    .in_a_hi  (in_a_hi),
    .in_b     (in_b),
    .p_valid  (w_p_valid),
    .p_tag    (w_p_tag),
    .p        (w_p)
  );

  // First beat loads so a window never inherits its predecessor's sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_last3 <= 1'b0;
    end else begin
      r_last3 <= w_p_valid & w_p_tag[0];
      if (w_p_valid) begin
        r_acc <= w_p_tag[1] ? w_p : r_acc + w_p;
      end
    end
  end

  assign w_lo             = r_acc[LANE_W-1:0];
  assign w_hi             = LANE_W'(unpack_hi(c_max_lane_w'(r_acc[2*LANE_W-1:LANE_W]),
                                              r_acc[LANE_W-1]));
  assign w_unused_acc_top = ^r_acc[PACK_W-1:2*LANE_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_lo    <= '0;
      r_out_hi    <= '0;
    end else begin
      r_out_valid <= r_last3;
      if (r_last3) begin
        r_out_lo <= w_lo;
        r_out_hi <= w_hi;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_lo    = r_out_lo;
  assign out_hi    = r_out_hi;
  assign beat_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_packed_dual_mac.sv
`default_nettype none
// Bench for packed_dual_mac: ACC_LEN=9 and ACC_LEN=1 instances on a shared
// input stream, scored against per-window integer sums.
module tb_packed_dual_mac;

  localparam int DW = 8;
  localparam int L9 = 2 * DW + $clog2(9) + 1;
  localparam int L1 = 2 * DW + 1;

  typedef struct {
    longint lo;
    longint hi;
    longint cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_a_lo = '0;
  logic [DW-1:0] in_a_hi = '0;
  logic [DW-1:0] in_b = '0;
  logic          out_valid9;
  logic [L9-1:0] out_lo9;
  logic [L9-1:0] out_hi9;
  logic [3:0]    beat_cnt9;
  logic          out_valid1;
  logic [L1-1:0] out_lo1;
  logic [L1-1:0] out_hi1;
  logic [0:0]    beat_cnt1;

  exp_t   q9[$];
  exp_t   q1[$];
  exp_t   e9;
  exp_t   e1;
  longint cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  int     n_pulse9 = 0;
  int     n_pulse1 = 0;
  longint last9_lo, last9_hi, last1_lo, last1_hi;
  longint m_lo = 0;
  longint m_hi = 0;
  int     m_cnt = 0;
  int     p0;

  packed_dual_mac #(.DATA_W(DW), .ACC_LEN(9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_a_lo(in_a_lo), .in_a_hi(in_a_hi), .in_b(in_b),
    .out_valid(out_valid9), .out_lo(out_lo9), .out_hi(out_hi9), .beat_cnt(beat_cnt9)
  );

  packed_dual_mac #(.DATA_W(DW), .ACC_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_a_lo(in_a_lo), .in_a_hi(in_a_hi), .in_b(in_b),
    .out_valid(out_valid1), .out_lo(out_lo1), .out_hi(out_hi1), .beat_cnt(beat_cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid9) begin
      n_pulse9++;
      last9_lo = $signed(out_lo9);
      last9_hi = $signed(out_hi9);
      if (q9.size() == 0) check("dut9 unexpected pulse", 1, 0);
      else begin
        e9 = q9.pop_front();
        check("dut9 out_lo", last9_lo, e9.lo);
        check("dut9 out_hi", last9_hi, e9.hi);
        check("dut9 pulse cycle", cyc, e9.cyc);
      end
    end
    if (out_valid1) begin
      n_pulse1++;
      last1_lo = $signed(out_lo1);
      last1_hi = $signed(out_hi1);
      if (q1.size() == 0) check("dut1 unexpected pulse", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("dut1 out_lo", last1_lo, e1.lo);
        check("dut1 out_hi", last1_hi, e1.hi);
        check("dut1 pulse cycle", cyc, e1.cyc);
      end
    end
  end

  function automatic int rnd8();
    if ($urandom_range(0, 7) == 0) return -128;
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Output of a beat sampled at the next posedge appears 4 edges later.
  task automatic beat(input int lo, input int hi, input int b);
    @(negedge clk);
    check("beat_cnt", beat_cnt9, m_cnt);
    in_valid = 1'b1;
    in_a_lo  = DW'(lo);
    in_a_hi  = DW'(hi);
    in_b     = DW'(b);
    m_lo += lo * b;
    m_hi += hi * b;
    m_cnt++;
    if (m_cnt == 9) begin
      q9.push_back('{m_lo, m_hi, cyc + 4});
      m_lo  = 0;
      m_hi  = 0;
      m_cnt = 0;
    end
    q1.push_back('{longint'(lo * b), longint'(hi * b), cyc + 4});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input bit with_beat);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = with_beat;
    in_a_lo  = DW'(rnd8());
    in_a_hi  = DW'(rnd8());
    in_b     = DW'(rnd8());
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    m_lo  = 0;
    m_hi  = 0;
    m_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset out_valid9", out_valid9, 0);
    check("reset out_lo9", out_lo9, 0);
    check("reset out_hi9", out_hi9, 0);
    check("reset beat_cnt9", beat_cnt9, 0);
    check("reset out_valid1", out_valid1, 0);
    check("reset out_lo1", out_lo1, 0);
    check("reset out_hi1", out_hi1, 0);
    check("reset beat_cnt1", beat_cnt1, 0);
    rst = 1'b0;

    // extreme operands
    p0 = n_pulse9; last9_lo = 0; last9_hi = 0;
    for (int i = 0; i < 9; i++) beat(-128, 127, -128);
    idle(6);
    check("t1 out_lo", last9_lo, 147456);
    check("t1 out_hi", last9_hi, -146304);
    check("t1 pulses", n_pulse9, p0 + 1);

    // borrow correction
    p0 = n_pulse9; last9_lo = 0; last9_hi = 0;
    for (int i = 0; i < 9; i++) beat(-1, 1, 1);
    idle(6);
    check("t2 out_lo", last9_lo, -9);
    check("t2 out_hi", last9_hi, 9);

    // bubbles
    p0 = n_pulse9; last9_lo = 0; last9_hi = 0;
    for (int i = 0; i < 9; i++) begin
      beat(-128, 127, -128);
      idle($urandom_range(1, 3));
    end
    idle(6);
    check("t3 out_lo", last9_lo, 147456);
    check("t3 out_hi", last9_hi, -146304);
    check("t3 pulses", n_pulse9, p0 + 1);

    // back-to-back windows
    p0 = n_pulse9;
    for (int i = 0; i < 27; i++) beat(rnd8(), rnd8(), rnd8());
    idle(6);
    check("t4 pulses", n_pulse9, p0 + 3);

    // reset mid-window, beat coincident with reset is dropped
    for (int i = 0; i < 5; i++) beat(rnd8(), rnd8(), rnd8());
    idle(5);
    do_reset(1'b1);
    p0 = n_pulse9; last9_lo = 0; last9_hi = 0;
    for (int i = 0; i < 9; i++) beat(2, 3, 4);
    idle(6);
    check("t5 out_lo", last9_lo, 72);
    check("t5 out_hi", last9_hi, 108);
    check("t5 pulses", n_pulse9, p0 + 1);

    // single-beat windows
    p0 = n_pulse1; last1_lo = 0; last1_hi = 0;
    beat(5, -7, -3);
    idle(6);
    check("t6 out_lo", last1_lo, -15);
    check("t6 out_hi", last1_hi, 21);
    check("t6 pulses", n_pulse1, p0 + 1);

    // random stream with random bubbles
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 3) idle(1);
      beat(rnd8(), rnd8(), rnd8());
    end
    idle(1);

    for (int i = 0; i < 20 && (q9.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check("q9 drained", q9.size(), 0);
    check("q1 drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
